mux_sel_arbiter: RTL

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

---
 rtl/mux_sel_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter that produces a registered mux select.
//
// Ports
//   clk      sole clock, all state on the rising edge
//   reset    synchronous active-high reset
//   req      per-requester request level [INs-1:0]
//   done     single-cycle strobe: current grantee has finished
//   sel      registered binary index of the grantee (downstream mux select)
//   grant    registered one-hot grant, grant[sel] is the only set bit while busy
//   busy     high while a grant is held
//   timeout  (only with MUX_SEL_ARBITER_TIMEOUT_EN) one-cycle pulse when a
//            grant is force-released after TIMEOUT cycles without done
//
// Parameters
//   INs      number of requesters, 2..32
//   TIMEOUT  maximum grant hold in cycles (only with MUX_SEL_ARBITER_TIMEOUT_EN)
//
// Optional feature macro: MUX_SEL_ARBITER_TIMEOUT_EN
module mux_sel_arbiter #(
    parameter int unsigned INs     = 5,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [INs-1:0]           req,
    input  logic                     done,
    output logic [$clog2(INs)-1:0]   sel,
    output logic [INs-1:0]           grant,
    output logic                     busy
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
    ,
    output logic                     timeout
`endif
);

    localparam int unsigned SW = $clog2(INs);
    localparam int unsigned PW = SW + 1;

    // Elaboration-time guard on the legal parameter range.
    if (INs < 2 || INs > 32 || TIMEOUT < 1) begin : g_bad_param
        $error("mux_sel_arbiter: INs must be 2..32 and TIMEOUT >= 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [SW-1:0]   ptr;
    logic [2*INs-1:0] rot;
    logic [PW-1:0]   sum;
    logic [SW-1:0]   pick;
    logic            pick_vld;
    logic            rel;

`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0]   cnt;
    logic            expire;
`endif

    // Round-robin search: rotate the doubled request vector so bit 0 is ptr,
    // take the first set bit and map the offset back to an index below INs.
    always_comb begin
        rot      = {req, req} >> ptr;
        pick     = '0;
        pick_vld = 1'b0;
        sum      = '0;
        for (int unsigned i = 0; i < INs; i++) begin
            if (!pick_vld && ((rot >> i) & (2*INs)'(1)) != '0) begin
                pick_vld = 1'b1;
                sum      = PW'(ptr) + PW'(i);
                if (sum >= PW'(INs)) begin
                    sum = sum - PW'(INs);
                end
                pick = SW'(sum);
            end
        end
    end

    // Release condition; done wins over an expiry on the same cycle.
    always_comb begin
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
        expire = (state == GRANT) && !done && (cnt == CW'(TIMEOUT - 1));
        rel    = (state == GRANT) && (done || expire);
`else
        rel    = (state == GRANT) && done;
`endif
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sel   <= '0;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
            cnt     <= '0;
            timeout <= 1'b0;
`endif
        end else begin
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
            timeout <= expire;
`endif
            case (state)
                IDLE: begin
                    // sel keeps its last value while nobody is requesting
                    if (pick_vld) begin
                        state <= GRANT;
                        sel   <= pick;
                        grant <= INs'(1) << pick;
                        busy  <= 1'b1;
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
                end
                GRANT: begin
                    // Always returns through IDLE, so grants never abut.
                    if (rel) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= (sel == SW'(INs - 1)) ? '0 : sel + SW'(1);
                    end
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
                    else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
